// File: rtl/apu_cluster_package.sv
// Shared constants for the APU cluster DSP path.
package apu_cluster_package;

    localparam int DSP_WIDTH    = 32;
    localparam int DSP_OP_WIDTH = 3;

    localparam int APU_DSP_RESP_FIFO_DEPTH = 4;

    localparam logic [DSP_OP_WIDTH-1:0] DSP_OP_MUL = 3'd1;
    localparam logic [DSP_OP_WIDTH-1:0] DSP_OP_DOT = 3'd2;
    localparam logic [DSP_OP_WIDTH-1:0] DSP_OP_MAC = 3'd3;

endpackage

// File: rtl/apu_resp_fifo.sv
// Generic synchronous FIFO, registered head (no fall-through).
module apu_resp_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rptr_q, wptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  wr, rd;

    function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rd      = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign wr      = push_i & (~full_o | rd);
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ptr_nxt(wptr_q);
            end
            if (rd) rptr_q <= ptr_nxt(rptr_q);
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/apu_dsp_mult_issue.sv
// Core-side issue/response front end for the shared DSP multiplier; credits
// bound outstanding ops so every unit result has a response slot.
module apu_dsp_mult_issue
    import apu_cluster_package::*;
#(
    parameter int TAG_WIDTH       = 4,
    parameter int RESP_FIFO_DEPTH = APU_DSP_RESP_FIFO_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [DSP_OP_WIDTH-1:0] req_op_i,
    input  logic [DSP_WIDTH-1:0]    req_opa_i,
    input  logic [DSP_WIDTH-1:0]    req_opb_i,
    input  logic [DSP_WIDTH-1:0]    req_opc_i,
    input  logic [1:0]              req_flags_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DSP_WIDTH-1:0]    resp_result_o,
    output logic [TAG_WIDTH-1:0]    resp_tag_o,
    output logic [1:0]              resp_status_o,
    output logic                    En_o,
    output logic [DSP_OP_WIDTH-1:0] Op_o,
    output logic [DSP_WIDTH-1:0]    OpA_o,
    output logic [DSP_WIDTH-1:0]    OpB_o,
    output logic [DSP_WIDTH-1:0]    OpC_o,
    output logic [1:0]              Flag_o,
    output logic [TAG_WIDTH-1:0]    Tag_o,
    input  logic [DSP_WIDTH-1:0]    Res_i,
    input  logic [TAG_WIDTH-1:0]    Tag_i,
    input  logic [1:0]              Status_i,
    input  logic                    Valid_i,
    input  logic                    Ready_i,
    output logic                    Ack_o,
    output logic                    error_o
);
    localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DSP_WIDTH-1:0] result;
        logic [TAG_WIDTH-1:0] tag;
        logic [1:0]           status;
    } resp_t;

    logic [CW-1:0] credit_q, inflight_q;
    logic          live_q;
    logic          fire, pop, push, res_ok;
    logic          fifo_full, fifo_empty;
    resp_t         push_data, head;

    // live_q keeps req_ready_o low while reset is asserted.
    assign req_ready_o = live_q & Ready_i & (credit_q != '0);
    assign fire        = req_valid_i & req_ready_o;
    assign resp_valid_o = ~fifo_empty;
    assign pop         = resp_valid_o & resp_ready_i;
    assign res_ok      = Valid_i & (inflight_q != '0);
    assign push        = res_ok & (~fifo_full | pop);
    assign Ack_o       = Valid_i;

    assign push_data     = '{result: Res_i, tag: Tag_i, status: Status_i};
    assign resp_result_o = head.result;
    assign resp_tag_o    = head.tag;
    assign resp_status_o = head.status;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= 1'b0;
            credit_q   <= CW'(RESP_FIFO_DEPTH);
            inflight_q <= '0;
            error_o    <= 1'b0;
            En_o       <= 1'b0;
            Op_o       <= '0;
            OpA_o      <= '0;
            OpB_o      <= '0;
            OpC_o      <= '0;
            Flag_o     <= '0;
            Tag_o      <= '0;
        end else begin
            live_q <= 1'b1;

            case ({fire, pop})
                2'b10:   credit_q <= credit_q - CW'(1);
                2'b01:   credit_q <= credit_q + CW'(1);
                default: credit_q <= credit_q;
            endcase

            case ({En_o, res_ok})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase

            // Unexpected or unstorable results are dropped and flagged.
            if (Valid_i && !push) error_o <= 1'b1;

            En_o <= fire;
            if (fire) begin
                Op_o   <= req_op_i;
                OpA_o  <= req_opa_i;
                OpB_o  <= req_opb_i;
                OpC_o  <= req_opc_i;
                Flag_o <= req_flags_i;
                Tag_o  <= req_tag_i;
            end else begin
                Op_o   <= '0;
                OpA_o  <= '0;
                OpB_o  <= '0;
                OpC_o  <= '0;
                Flag_o <= '0;
            end
        end
    end

    apu_resp_fifo #(
        .DATA_WIDTH ($bits(resp_t)),
        .DEPTH      (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
